data_mem_responder: RTL and testbench

Multi-cycle data-memory responder that serves load/store requests from the datapath's memory stage over a valid/ready request channel and a one-cycle response strobe. It supports word, halfword and byte stores with lane masking and a configurable wait-state latency. Load data is returned as the full aligned word; byte and halfword extraction stays in the datapath. It replaces the single-cycle data memory when the pipeline is built with a stall-capable memory stage.

---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory behind a valid/ready request channel.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles and completes with a one-cycle
// RespValid strobe. The write and the ReadData update happen on the edge that enters RESP.
// Optional feature: define DMEM_ERR_CHECK_EN to enable alignment, range and encoding checks
// reported on AddrError. Without it, AddrError is 0, alignment is forced and the word
// index wraps modulo DEPTH_WORDS.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  StoreMode,
  output logic        RespValid,
  output logic [31:0] ReadData,
  output logic        AddrError
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CntLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  mode_q;
  logic        rd_q, wr_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit;
  logic [31:0]   c_addr, c_wdata;
  logic [1:0]    c_mode;
  logic          c_rd, c_wr, c_err;
  logic [3:0]    c_be;
  logic [31:0]   c_wbus, c_old, c_merged;
  logic [AW-1:0] c_idx;

  assign accept    = ReqValid & (MemRead | MemWrite) & (state_q == StIdle);
  assign ReqReady  = (state_q == StIdle);
  assign RespValid = (state_q == StResp);
  assign ReadData  = rdata_q;
  assign AddrError = err_q;

  // Next-state logic: wait counter runs only in WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Commit fires on the edge entering RESP; with zero wait states that is the accept edge,
  // so the live inputs stand in for the not-yet-latched request.
  assign commit  = (state_d == StResp) && (state_q != StResp);
  assign c_addr  = (state_q == StIdle) ? Address   : addr_q;
  assign c_wdata = (state_q == StIdle) ? WriteData : wdata_q;
  assign c_mode  = (state_q == StIdle) ? StoreMode : mode_q;
  assign c_rd    = (state_q == StIdle) ? MemRead   : rd_q;
  assign c_wr    = (state_q == StIdle) ? MemWrite  : wr_q;
  assign c_idx   = c_addr[AW+1:2];
  assign c_old   = mem[c_idx];

  // Lane enables, replicated write bus, error decode and the post-write word
  always_comb begin
    c_be   = 4'b1111;
    c_wbus = c_wdata;
    unique case (c_mode)
      2'b01: begin
        c_be   = c_addr[1] ? 4'b1100 : 4'b0011;
        c_wbus = {2{c_wdata[15:0]}};
      end
      2'b10: begin
        c_be   = 4'b0001 << c_addr[1:0];
        c_wbus = {4{c_wdata[7:0]}};
      end
      default: c_be = 4'b1111;
    endcase
`ifdef DMEM_ERR_CHECK_EN
    c_err = (c_rd & c_wr)
          | (c_wr & (c_mode == 2'b11))
          | (c_wr & (c_mode == 2'b01) & c_addr[0])
          | (c_wr & (c_mode == 2'b00) & (c_addr[1:0] != 2'b00))
          | ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
    c_err = 1'b0;
`endif
    if (!c_wr || c_err) c_be = 4'b0000;
    c_merged = c_old;
    for (int i = 0; i < 4; i++) begin
      if (c_be[i]) c_merged[8*i +: 8] = c_wbus[8*i +: 8];
    end
  end

`ifndef DMEM_ERR_CHECK_EN
  logic unused_bits;
  assign unused_bits = ^{c_rd, c_addr[31:AW+2]};
`endif

  // Control, request latch and response registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      mode_q  <= 2'b00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= Address;
        wdata_q <= WriteData;
        mode_q  <= StoreMode;
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
      end
      if (commit) begin
        rdata_q <= c_err ? 32'd0 : c_merged;
        err_q   <= c_err;
      end
    end
  end

  // Storage write; not reset, and suppressed while Reset is held
  always_ff @(posedge Clk) begin
    if (commit && !Reset) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wbus[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, reset/no-accept/zero-wait sequences and
// randomized requests checked against a byte-addressed reference model.
module tb_data_mem_responder;

  localparam int unsigned Depth = 64;
  localparam int unsigned Wait  = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, mem_write, mem_read, resp_valid, addr_error;
  logic [31:0] address, write_data, read_data;
  logic [1:0]  store_mode;
  logic        z_valid, z_ready, z_write, z_read, z_resp, z_err;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [1:0]  z_mode;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 Clk = ~Clk;

  data_mem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(Wait)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(req_valid), .ReqReady(req_ready),
    .Address(address), .WriteData(write_data), .MemWrite(mem_write), .MemRead(mem_read),
    .StoreMode(store_mode), .RespValid(resp_valid), .ReadData(read_data),
    .AddrError(addr_error)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .ReqValid(z_valid), .ReqReady(z_ready),
    .Address(z_addr), .WriteData(z_wdata), .MemWrite(z_write), .MemRead(z_read),
    .StoreMode(z_mode), .RespValid(z_resp), .ReadData(z_rdata), .AddrError(z_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed storage, sizes as byte counts
  logic [7:0] mem_b [Depth*4];

  function automatic void model(input logic rd, input logic wr, input logic [1:0] mode,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
    int unsigned idx, size, base;
    idx = addr >> 2;
`ifdef DMEM_ERR_CHECK_EN
    err = (rd && wr) || (idx >= Depth);
    if (wr) begin
      if (mode == 2'b11) err = 1'b1;
      if (mode == 2'b01 && addr % 2 != 0) err = 1'b1;
      if (mode == 2'b00 && addr % 4 != 0) err = 1'b1;
    end
`else
    err = 1'b0;
    idx = idx % Depth;
`endif
    if (!err && wr) begin
      case (mode)
        2'b10:   begin size = 1; base = idx * 4 + addr % 4;           end
        2'b01:   begin size = 2; base = idx * 4 + ((addr % 4) / 2) * 2; end
        default: begin size = 4; base = idx * 4;                      end
      endcase
      for (int b = 0; b < int'(size); b++) mem_b[base + b] = wdata[8*b +: 8];
    end
    rdata = 32'd0;
    if (!err) for (int b = 0; b < 4; b++) rdata[8*b +: 8] = mem_b[idx * 4 + b];
  endfunction

  // One full request on the WAIT_CYCLES=2 instance, with timing and result checks
  task automatic txn(input string name, input logic rd, input logic wr, input logic [1:0] mode,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_err, input logic [31:0] exp_data);
    int k;
    @(posedge Clk); #1;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; store_mode = mode;
    address = addr; write_data = wdata;
    k = 0;
    do begin @(negedge Clk); k++; end while (!req_ready && k < 20);
    @(posedge Clk); #1;
    // Scramble request fields after accept; the latched copy must be used
    req_valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
    store_mode = 2'($urandom); address = $urandom; write_data = $urandom;
    k = 0;
    do begin @(negedge Clk); k++; end while (!resp_valid && k < 20);
    check({name, " latency"}, k, Wait + 1);
    check({name, " err"}, addr_error, exp_err);
    check({name, " data"}, read_data, exp_data);
    @(negedge Clk);
    check({name, " resp/ready after"}, {resp_valid, req_ready}, 2'b01);
    check({name, " data hold"}, read_data, exp_data);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rd, input logic wr, input logic [1:0] mode,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mode = mode; v.addr = addr; v.wdata = wdata;
    v.err = err; v.data = data;
    tbl.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] d, prior;

    Reset = 1'b1;
    req_valid = 0; mem_read = 0; mem_write = 0; store_mode = 0; address = 0; write_data = 0;
    z_valid = 0; z_read = 0; z_write = 0; z_mode = 0; z_addr = 0; z_wdata = 0;
    #3;
    check("reset ready",     req_ready,  1);
    check("reset resp",      resp_valid, 0);
    check("reset data",      read_data,  0);
    check("reset err",       addr_error, 0);
    check("reset0 ready",    z_ready,    1);
    check("reset0 resp",     z_resp,     0);
    check("reset0 data",     z_rdata,    0);
    check("reset0 err",      z_err,      0);
    #19 Reset = 1'b0;

    // ReqValid with neither read nor write: never accepted
    @(posedge Clk); #1;
    req_valid = 1'b1; address = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("no-op request", {resp_valid, req_ready}, 2'b01);
    end
    @(posedge Clk); #1;
    req_valid = 1'b0;

    // Directed table
    add(0, 1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    add(1, 0, 2'b00, 32'h10, 32'h0,        0, 32'hDEADBEEF);
    add(0, 1, 2'b10, 32'h13, 32'hFFFFFF5A, 0, 32'h5AADBEEF);
    add(1, 0, 2'b00, 32'h10, 32'h0,        0, 32'h5AADBEEF);
    add(0, 1, 2'b01, 32'h10, 32'hABCD1234, 0, 32'h5AAD1234);
    add(1, 0, 2'b00, 32'h10, 32'h0,        0, 32'h5AAD1234);
    add(0, 1, 2'b01, 32'h12, 32'h00009876, 0, 32'h98761234);
    add(0, 1, 2'b10, 32'h11, 32'h00000077, 0, 32'h98767734);
    add(1, 0, 2'b11, 32'h11, 32'h0,        0, 32'h98767734);
`ifdef DMEM_ERR_CHECK_EN
    add(0, 1, 2'b01, 32'h11,      32'h0000BBBB, 1, 32'h0);
    add(1, 0, 2'b00, 32'h10,      32'h0,        0, 32'h98767734);
    add(1, 0, 2'b00, Depth * 4,   32'h0,        1, 32'h0);
    add(0, 1, 2'b00, 32'h12,      32'h11111111, 1, 32'h0);
    add(1, 1, 2'b00, 32'h10,      32'h22222222, 1, 32'h0);
    add(0, 1, 2'b11, 32'h10,      32'h33333333, 1, 32'h0);
    add(1, 0, 2'b00, 32'h10,      32'h0,        0, 32'h98767734);
`else
    add(0, 1, 2'b01, 32'h11,             32'h00004321, 0, 32'h98764321);
    add(0, 1, 2'b00, 32'h13,             32'h01020304, 0, 32'h01020304);
    add(1, 0, 2'b00, Depth * 4 + 32'h10, 32'h0,        0, 32'h01020304);
    add(1, 1, 2'b10, 32'h10,             32'h000000EE, 0, 32'h010203EE);
    add(0, 1, 2'b11, 32'h11,             32'hA5A5A5A5, 0, 32'hA5A5A5A5);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].mode, tbl[i].addr, tbl[i].wdata, e, d);
      txn($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].mode, tbl[i].addr,
          tbl[i].wdata, tbl[i].err, tbl[i].data);
    end

    // Fill every word so later loads have defined contents
    for (int w = 0; w < int'(Depth); w++) begin
      logic [31:0] v;
      v = $urandom;
      model(0, 1, 2'b00, w * 4, v, e, d);
      txn("fill", 0, 1, 2'b00, w * 4, v, e, d);
    end

    // Reset during WAIT discards a pending store
    model(1, 0, 2'b00, 32'h20, 32'h0, e, prior);
    @(posedge Clk); #1;
    req_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; store_mode = 2'b00;
    address = 32'h20; write_data = 32'hFFFFFFFF;
    @(negedge Clk);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    @(negedge Clk);
    check("reset-in-wait ready before", req_ready, 0);
    #2 Reset = 1'b1;
    #1;
    check("reset-in-wait ready now", req_ready, 1);
    check("reset-in-wait resp", resp_valid, 0);
    @(posedge Clk);
    @(posedge Clk); #2 Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check("after reset no resp", {resp_valid, req_ready}, 2'b01);
    end
    txn("reset-in-wait load", 1, 0, 2'b00, 32'h20, 32'h0, 0, prior);

    // Randomized requests against the model
    for (int n = 0; n < 150; n++) begin
      logic        rd, wr;
      logic [1:0]  mode;
      logic [31:0] addr, wdata;
      int          sel;
      sel = $urandom_range(0, 9);
      rd = (sel <= 3) || (sel == 9);
      wr = (sel >= 4);
      mode = 2'($urandom);
      addr = ($urandom_range(0, Depth + 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      wdata = $urandom;
      model(rd, wr, mode, addr, wdata, e, d);
      txn($sformatf("rand%0d", n), rd, wr, mode, addr, wdata, e, d);
    end

    // Zero wait states, ReqValid held: accept every other cycle, response right after
    @(posedge Clk); #1;
    z_valid = 1'b1; z_write = 1'b1; z_read = 1'b0; z_mode = 2'b00;
    z_addr = 32'h0; z_wdata = 32'hCAFEF00D;
    @(negedge Clk);
    check("w0 first accept", {z_resp, z_ready}, 2'b01);
    @(posedge Clk); #1;
    z_write = 1'b0; z_read = 1'b1; z_wdata = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      check($sformatf("w0 cycle%0d", i), {z_resp, z_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i % 2 == 1) begin
        check($sformatf("w0 data%0d", i), z_rdata, 32'hCAFEF00D);
        check($sformatf("w0 err%0d", i), z_err, 0);
      end
    end
    @(posedge Clk); #1;
    z_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
